dac_writer_multi: RTL and testbench

DAC_WRITER_MULTI -- requirements
Module: dac_writer_multi

---
 rtl/dac_pkg.sv | 23 ++
 rtl/spi_frame_shifter.sv | 76 +++++++
 rtl/dac_writer_multi.sv | 170 +++++++++++++++++
 tb/tb_dac_writer_multi.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dac_pkg
// Purpose  : Shared state encoding and frame constants for the DAC writer.
// Revision : 1.0 - initial release
// ============================================================================
package dac_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        GAP   = 3'd3,
        LDAC  = 3'd4,
        DONE  = 3'd5
    } dac_state_e;

    localparam logic [3:0] CMD_WRITE_INPUT  = 4'h1;
    localparam logic [3:0] CMD_WRITE_UPDATE = 4'h3;
    localparam int         c_hdr_w          = 8;

endpackage
`default_nettype wire

// File: rtl/spi_frame_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_shifter
// Purpose  : Shifts one MSB-first SPI frame (CPOL=0, CPHA=0), CS active-low.
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_shifter #(
    parameter int FRAME_W  = 24,
    parameter int SCLK_DIV = 2
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               start_i,
    input  logic [FRAME_W-1:0] frame_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               sclk_o,
    output logic               mosi_o,
    output logic               cs_o
);

    localparam int c_div_w = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int c_bit_w = $clog2(FRAME_W);

    logic               r_busy;
    logic               r_phase;
    logic [c_div_w-1:0] r_div;
    logic [c_bit_w-1:0] r_bit;
    logic [FRAME_W-1:0] r_shreg;
    logic               w_div_end;
    logic               w_last;

    assign w_div_end = (r_div == c_div_w'(SCLK_DIV - 1));
    assign w_last    = r_busy & r_phase & w_div_end & (r_bit == c_bit_w'(FRAME_W - 1));

    // Low half first, so MOSI set at CS fall / SCLK fall gets SCLK_DIV cycles of setup
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_busy  <= 1'b0;
            r_phase <= 1'b0;
            r_div   <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
        end else if (start_i && !r_busy) begin
            r_busy  <= 1'b1;
            r_phase <= 1'b0;
            r_div   <= '0;
            r_bit   <= '0;
            r_shreg <= frame_i;
        end else if (r_busy) begin
            if (w_div_end) begin
                r_div <= '0;
                if (!r_phase) begin
                    r_phase <= 1'b1;
                end else begin
                    r_phase <= 1'b0;
                    r_shreg <= {r_shreg[FRAME_W-2:0], 1'b0};
                    r_bit   <= r_bit + 1'b1;
                    if (w_last) begin
                        r_busy <= 1'b0;
                    end
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign busy_o = r_busy;
    assign done_o = w_last;
    assign cs_o   = ~r_busy;
    assign sclk_o = r_busy & r_phase;
    assign mosi_o = r_busy & r_shreg[FRAME_W-1];

endmodule
`default_nettype wire

// File: rtl/dac_writer_multi.sv
`default_nettype none
// ============================================================================
// Module   : dac_writer_multi
// Purpose  : Writes enabled DAC channels over SPI, optional LDAC sync update.
// Revision : 1.0 - initial release
// ============================================================================
module dac_writer_multi
    import dac_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int DATA_W   = 16,
    parameter int SCLK_DIV = 2,
    parameter int CS_GAP   = 2,
    parameter int LDAC_W   = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     start_i,
    input  logic [NUM_CH*DATA_W-1:0] data_i,
    input  logic [NUM_CH-1:0]        ch_en_i,
    input  logic                     sync_mode_i,
    output logic                     spi_sclk_o,
    output logic                     spi_mosi_o,
    output logic                     spi_cs_o,
    output logic                     ldac_no,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     overrun_o
);

    localparam int c_frame_w = c_hdr_w + DATA_W;
    localparam int c_cnt_max = (CS_GAP > LDAC_W) ? CS_GAP : LDAC_W;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    dac_state_e                r_state;
    dac_state_e                w_next;
    logic [NUM_CH*DATA_W-1:0]  r_data;
    logic [NUM_CH-1:0]         r_pending;
    logic                      r_sync;
    logic                      r_sent_any;
    logic                      r_overrun;
    logic [c_cnt_w-1:0]        r_cnt;

    logic [NUM_CH*DATA_W-1:0]  w_src_data;
    logic [NUM_CH-1:0]         w_src_mask;
    logic                      w_src_sync;
    logic                      w_has_ch;
    logic [3:0]                w_sel_ch;
    logic [DATA_W-1:0]         w_sel_sample;
    logic [c_frame_w-1:0]      w_frame;
    logic                      w_launch;
    logic                      w_shift_busy;
    logic                      w_frame_done;

    // In IDLE the frame is built straight from the inputs so the first CS fall
    // coincides with the LOAD cycle; afterwards the latched copies are used.
    assign w_src_data = (r_state == IDLE) ? data_i      : r_data;
    assign w_src_mask = (r_state == IDLE) ? ch_en_i     : r_pending;
    assign w_src_sync = (r_state == IDLE) ? sync_mode_i : r_sync;

    always_comb begin
        w_has_ch     = 1'b0;
        w_sel_ch     = '0;
        w_sel_sample = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_src_mask[k]) begin
                w_has_ch     = 1'b1;
                w_sel_ch     = 4'(k);
                w_sel_sample = w_src_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_frame = {(w_src_sync ? CMD_WRITE_INPUT : CMD_WRITE_UPDATE), w_sel_ch, w_sel_sample};

    // Channel selection happens on the transition into LOAD
    always_comb begin
        w_next   = r_state;
        w_launch = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_next   = LOAD;
                    w_launch = w_has_ch;
                end
            end
            LOAD: begin
                if (w_shift_busy)              w_next = SHIFT;
                else if (r_sync && r_sent_any) w_next = LDAC;
                else                           w_next = DONE;
            end
            SHIFT: begin
                if (w_frame_done) w_next = GAP;
            end
            GAP: begin
                if (r_cnt == c_cnt_w'(CS_GAP - 1)) begin
                    if (w_has_ch) begin
                        w_next   = LOAD;
                        w_launch = 1'b1;
                    end else if (r_sync) begin
                        w_next = LDAC;
                    end else begin
                        w_next = DONE;
                    end
                end
            end
            LDAC: begin
                if (r_cnt == c_cnt_w'(LDAC_W - 1)) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_data     <= '0;
            r_pending  <= '0;
            r_sync     <= 1'b0;
            r_sent_any <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (r_state == IDLE && start_i) begin
                r_data     <= data_i;
                r_sync     <= sync_mode_i;
                r_pending  <= ch_en_i;
                r_sent_any <= 1'b0;
            end
            if (w_launch) begin
                r_pending  <= w_src_mask & ~(NUM_CH'(1) << w_sel_ch);
                r_sent_any <= 1'b1;
            end
            if (start_i && r_state != IDLE) begin
                r_overrun <= 1'b1;
            end
        end
    end

    spi_frame_shifter #(
        .FRAME_W  (c_frame_w),
        .SCLK_DIV (SCLK_DIV)
    ) u_shifter (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .start_i  (w_launch),
        .frame_i  (w_frame),
        .busy_o   (w_shift_busy),
        .done_o   (w_frame_done),
        .sclk_o   (spi_sclk_o),
        .mosi_o   (spi_mosi_o),
        .cs_o     (spi_cs_o)
    );

    assign busy_o    = (r_state != IDLE) && (r_state != DONE);
    assign done_o    = (r_state == DONE);
    assign ldac_no   = (r_state != LDAC);
    assign overrun_o = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_dac_writer_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_writer_multi
// Purpose  : Self-checking bench with SPI slave model and update-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_writer_multi;

    localparam int NUM_CH    = 2;
    localparam int DATA_W    = 16;
    localparam int SCLK_DIV  = 2;
    localparam int CS_GAP    = 2;
    localparam int LDAC_W    = 2;
    localparam int FRAME_W   = 8 + DATA_W;
    localparam int FRAME_CYC = FRAME_W * 2 * SCLK_DIV;
    localparam int BUDGET    = 600;

    logic                     clk;
    logic                     reset_ni;
    logic                     start_i;
    logic [NUM_CH*DATA_W-1:0] data_i;
    logic [NUM_CH-1:0]        ch_en_i;
    logic                     sync_mode_i;
    logic                     spi_sclk_o;
    logic                     spi_mosi_o;
    logic                     spi_cs_o;
    logic                     ldac_no;
    logic                     busy_o;
    logic                     done_o;
    logic                     overrun_o;

    dac_writer_multi #(
        .NUM_CH   (NUM_CH),
        .DATA_W   (DATA_W),
        .SCLK_DIV (SCLK_DIV),
        .CS_GAP   (CS_GAP),
        .LDAC_W   (LDAC_W)
    ) dut (
        .clk_i       (clk),
        .reset_ni    (reset_ni),
        .start_i     (start_i),
        .data_i      (data_i),
        .ch_en_i     (ch_en_i),
        .sync_mode_i (sync_mode_i),
        .spi_sclk_o  (spi_sclk_o),
        .spi_mosi_o  (spi_mosi_o),
        .spi_cs_o    (spi_cs_o),
        .ldac_no     (ldac_no),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overrun_o   (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SPI slave model, sampled mid-cycle
    logic [FRAME_W-1:0] cap_frame[$];
    int                 cap_bits[$];
    int                 cap_low[$];
    int                 cap_gap[$];
    int                 cap_hold[$];
    logic [FRAME_W-1:0] sh;
    int                 nbits, low_cnt, hi_run, gap_at_fall, stable;
    bit                 in_frame, hold_bad, hold_bit, quiet_bad;
    logic               prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;

    always @(negedge clk) begin
        if (!reset_ni) begin
            in_frame  = 1'b0;
            prev_cs   = 1'b1;
            prev_sclk = 1'b0;
            prev_mosi = 1'b0;
            hi_run    = 0;
        end else begin
            if (!spi_cs_o) begin
                if (prev_cs) begin
                    in_frame    = 1'b1;
                    sh          = '0;
                    nbits       = 0;
                    low_cnt     = 0;
                    gap_at_fall = hi_run;
                    stable      = 0;
                    hold_bad    = 1'b0;
                end
                low_cnt++;
                hi_run = 0;
                if (!spi_sclk_o) begin
                    if (!prev_cs && !prev_sclk && spi_mosi_o == prev_mosi) stable++;
                    else stable = 1;
                end else if (!prev_sclk) begin
                    check_eq("mosi_setup", stable, SCLK_DIV);
                    sh       = {sh[FRAME_W-2:0], spi_mosi_o};
                    hold_bit = spi_mosi_o;
                    nbits++;
                end else if (spi_mosi_o != hold_bit) begin
                    hold_bad = 1'b1;
                end
            end else begin
                if (!prev_cs && in_frame) begin
                    cap_frame.push_back(sh);
                    cap_bits.push_back(nbits);
                    cap_low.push_back(low_cnt);
                    cap_gap.push_back(gap_at_fall);
                    cap_hold.push_back(int'(hold_bad));
                end
                in_frame = 1'b0;
                hi_run++;
                if (spi_sclk_o || spi_mosi_o) quiet_bad = 1'b1;
            end
            prev_cs   = spi_cs_o;
            prev_sclk = spi_sclk_o;
            prev_mosi = spi_mosi_o;
        end
    end

    bit ovr_model = 1'b0;

    // Caller is always #1 after a rising edge; ovr_at < 0 means "in the DONE cycle"
    task automatic run_update(input logic [NUM_CH-1:0] mask, input logic [NUM_CH*DATA_W-1:0] data,
                              input bit sync, input int ovr_at, input int rst_at);
        logic [FRAME_W-1:0] exp_q[$];
        int n, exp_done, done_t, ldac_cnt, ldac_t, ovr_t;
        bit aborted;
        for (int k = 0; k < NUM_CH; k++) begin
            if (mask[k]) exp_q.push_back({(sync ? 4'h1 : 4'h3), 4'(k), data[k*DATA_W +: DATA_W]});
        end
        n        = exp_q.size();
        exp_done = (n == 0) ? 2 : n * (FRAME_CYC + CS_GAP) + ((sync) ? LDAC_W : 0) + 1;
        ovr_t    = (ovr_at < 0) ? exp_done : ovr_at;
        cap_frame.delete(); cap_bits.delete(); cap_low.delete(); cap_gap.delete(); cap_hold.delete();
        quiet_bad = 1'b0;
        data_i = data; ch_en_i = mask; sync_mode_i = sync; start_i = 1'b1;
        @(posedge clk); #1;
        data_i = ~data; ch_en_i = ~mask; sync_mode_i = ~sync;
        done_t = 0; ldac_cnt = 0; ldac_t = 0; aborted = 1'b0;
        for (int t = 1; t <= BUDGET; t++) begin
            start_i = (t == ovr_t);
            if (t == ovr_t) ovr_model = 1'b1;
            if (t == rst_at) begin
                reset_ni = 1'b0;
                #1;
                check_eq("rst_cs", spi_cs_o, 1'b1);
                check_eq("rst_sclk", spi_sclk_o, 1'b0);
                check_eq("rst_busy", busy_o, 1'b0);
                check_eq("rst_done", done_o, 1'b0);
                check_eq("rst_ldac", ldac_no, 1'b1);
                check_eq("rst_overrun", overrun_o, 1'b0);
                ovr_model = 1'b0;
                @(posedge clk); #1;
                reset_ni = 1'b1;
                aborted  = 1'b1;
                break;
            end
            @(negedge clk);
            if (t == 1) check_eq("busy_first", busy_o, 1'b1);
            if (!ldac_no) begin
                if (ldac_cnt == 0) ldac_t = t;
                ldac_cnt++;
            end
            if (done_o) begin
                done_t = t;
                check_eq("busy_at_done", busy_o, 1'b0);
                break;
            end
            @(posedge clk); #1;
        end
        if (aborted) begin
            start_i = 1'b0;
            return;
        end
        if (done_t != 0) begin
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        check_eq("done_cycle", done_t, exp_done);
        check_eq("done_single", done_o, 1'b0);
        check_eq("ldac_cycles", ldac_cnt, (sync && n > 0) ? LDAC_W : 0);
        if (sync && n > 0) check_eq("ldac_start", ldac_t, n * (FRAME_CYC + CS_GAP) + 1);
        check_eq("frame_count", cap_frame.size(), n);
        for (int i = 0; i < n && i < cap_frame.size(); i++) begin
            check_eq("frame_data", cap_frame[i], exp_q[i]);
            check_eq("frame_bits", cap_bits[i], FRAME_W);
            check_eq("cs_low_cycles", cap_low[i], FRAME_CYC);
            check_eq("mosi_hold", cap_hold[i], 0);
            if (i > 0) check_eq("cs_gap", cap_gap[i], CS_GAP);
        end
        check_eq("bus_quiet", quiet_bad, 1'b0);
        check_eq("overrun", overrun_o, ovr_model);
    endtask

    initial begin
        logic [NUM_CH*DATA_W-1:0] base;
        logic [NUM_CH*DATA_W-1:0] rd;
        logic [NUM_CH-1:0]        rm;
        base        = {16'h8000, 16'h1234};
        reset_ni    = 1'b0;
        start_i     = 1'b0;
        data_i      = '0;
        ch_en_i     = '0;
        sync_mode_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_cs", spi_cs_o, 1'b1);
        check_eq("reset_sclk", spi_sclk_o, 1'b0);
        check_eq("reset_mosi", spi_mosi_o, 1'b0);
        check_eq("reset_ldac", ldac_no, 1'b1);
        check_eq("reset_busy", busy_o, 1'b0);
        check_eq("reset_done", done_o, 1'b0);
        check_eq("reset_overrun", overrun_o, 1'b0);
        @(posedge clk); #1;
        reset_ni = 1'b1;
        @(posedge clk); #1;

        run_update(2'b11, base, 1'b0, 0, 0);
        run_update(2'b11, base, 1'b1, 0, 0);
        run_update(2'b10, base, 1'b0, 0, 0);
        run_update(2'b00, base, 1'b0, 0, 0);
        run_update(2'b11, base, 1'b0, 11, 0);
        run_update(2'b01, 32'hA5A5_7FFF, 1'b1, -1, 0);
        run_update(2'b10, 32'h0001_FFFF, 1'b0, 0, 0);
        run_update(2'b11, base, 1'b0, 0, 40);
        run_update(2'b11, base, 1'b0, 0, 0);

        for (int r = 0; r < 12; r++) begin
            rm = NUM_CH'($urandom_range(0, 3));
            for (int k = 0; k < NUM_CH; k++) rd[k*DATA_W +: DATA_W] = DATA_W'($urandom);
            run_update(rm, rd, 1'($urandom_range(0, 1)),
                       (rm != 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 90) : 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
